// File: rtl/imem_uart_loader.sv
// UART boot loader: receives 8N1 bytes, builds a little-endian length then
// little-endian instruction words, and writes them into instruction memory.
module imem_uart_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx,
    output logic [31:0] o_waddr,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_bmask,
    output logic        o_wren,
    output logic        o_hold,
    output logic        o_done,
    output logic        o_err
);

    localparam int AW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] L_LEN  = 2'd0;
    localparam logic [1:0] L_DATA = 2'd1;
    localparam logic [1:0] L_DONE = 2'd2;

    logic          sync1_q, sync2_q, prev_q;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          byte_vld, frame_err;

    logic [1:0]    ld_state_q, ld_state_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [23:0]   asm_q, asm_d;
    logic [AW-1:0] n_q, n_d;
    logic [AW-1:0] word_cnt_q, word_cnt_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    bmask_q, bmask_d;
    logic          wren_q, wren_d;
    logic          err_q, err_d;
    logic [31:0]   full_word;

    // The stop-bit sample drops straight back to RX_IDLE, so a start bit that
    // follows without an idle gap is still caught by the edge detector.
    always_comb begin
        rx_state_d = rx_state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_vld   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    rx_state_d = RX_START;
                    cnt_d      = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_END) begin
                    cnt_d      = '0;
                    bit_d      = '0;
                    rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_END) begin
                    cnt_d   = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_END) begin
                    cnt_d      = '0;
                    byte_vld   = sync2_q;
                    frame_err  = !sync2_q;
                    rx_state_d = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            prev_q     <= 1'b1;
            rx_state_q <= RX_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
        end else begin
            sync1_q    <= i_rx;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            rx_state_q <= rx_state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
        end
    end

    // Lower three bytes shift in from the top, so the fourth byte completes the word.
    assign full_word = {shift_q, asm_q};

    always_comb begin
        ld_state_d = ld_state_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        n_d        = n_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        bmask_d    = 4'h0;
        wren_d     = 1'b0;
        err_d      = err_q;
        case (ld_state_q)
            L_LEN: begin
                if (frame_err) begin
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                end else if (byte_vld) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        if (full_word == 32'd0) begin
                            ld_state_d = L_DONE;
                        end else if (full_word > 32'(DEPTH)) begin
                            err_d = 1'b1;
                        end else begin
                            n_d        = full_word[AW-1:0];
                            word_cnt_d = '0;
                            ld_state_d = L_DATA;
                        end
                    end else begin
                        asm_d      = {shift_q, asm_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            L_DATA: begin
                if (wren_q) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == n_q - 1'b1) ld_state_d = L_DONE;
                end
                if (frame_err) begin
                    err_d      = 1'b1;
                    byte_cnt_d = '0;
                    ld_state_d = L_LEN;
                end else if (byte_vld) begin
                    if (byte_cnt_q == 2'd3) begin
                        byte_cnt_d = '0;
                        wren_d     = 1'b1;
                        bmask_d    = 4'hF;
                        waddr_d    = word_cnt_q;
                        wdata_d    = full_word;
                    end else begin
                        asm_d      = {shift_q, asm_q[23:8]};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            L_DONE: ;
            default: ld_state_d = L_LEN;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ld_state_q <= L_LEN;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            n_q        <= '0;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            bmask_q    <= 4'h0;
            wren_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ld_state_q <= ld_state_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            n_q        <= n_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            bmask_q    <= bmask_d;
            wren_q     <= wren_d;
            err_q      <= err_d;
        end
    end

    assign o_waddr = {{(32 - AW){1'b0}}, waddr_q};
    assign o_wdata = wdata_q;
    assign o_bmask = bmask_q;
    assign o_wren  = wren_q;
    assign o_hold  = (ld_state_q != L_DONE);
    assign o_done  = (ld_state_q == L_DONE);
    assign o_err   = err_q;

endmodule

// File: doc/imem_uart_loader.md
# imem_uart_loader

UART boot loader that writes a program image into the instruction memory's write port, the writer side of the read-only fetch path. It receives 8N1 serial bytes, assembles little-endian 32-bit words and issues one word write per instruction. The core is held in reset until the image is complete. It sits between the board RX pin and the memory's `i_addr`/`i_wdata`/`i_bmask`/`i_wren` inputs, muxed against the fetch address while `o_hold` is high.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `DEPTH`, default 2048: instruction-memory depth in 32-bit words.
- `i_clk` in 1: system clock; all logic rises on it.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_rx` in 1: UART RX line; idles high; asynchronous to `i_clk`.
- `o_waddr` out 32: word address, driven straight to the memory's `i_addr`, not byte-shifted.
- `o_wdata` out 32: assembled instruction word.
- `o_bmask` out 4: byte mask; 4'hF while `o_wren`=1, else 4'h0.
- `o_wren` out 1: one-cycle write strobe.
- `o_hold` out 1: core reset request; 1 until the load is done.
- `o_done` out 1: image fully written. Sticky until reset.
- `o_err` out 1: sticky error, set by a framing error or an oversize length.

## Operation
- RX front end:
  - `i_rx` passes through a 2-flop synchronizer that resets to 1.
  - Bit FSM states: RX_IDLE → RX_START → RX_DATA → RX_STOP → RX_IDLE.
  - RX_IDLE: on a synced falling edge, wait CLKS_PER_BIT/2 (floor) cycles to reach mid start bit. If the line is high there, it is a glitch: return to RX_IDLE.
  - RX_DATA: 8 bits, LSB first, each sampled CLKS_PER_BIT cycles after the previous sample.
  - RX_STOP: sample the stop bit. If 1, pulse `byte_vld` for one cycle. If 0, pulse `frame_err` and drop the byte.
- Loader FSM states: L_LEN → L_DATA → L_DONE.
  - L_LEN: collect 4 bytes, little-endian, into the word count N.
    - N = 0 → L_DONE.
    - N > DEPTH → set `o_err`, clear the byte counter, stay in L_LEN.
    - Otherwise → L_DATA with word counter = 0.
  - L_DATA: byte k of each word goes to `o_wdata[8k+7:8k]`.
    - The 4th byte's `byte_vld` causes `o_wren`=1 on the next cycle, with `o_waddr` = word counter and `o_wdata` = assembled word.
    - The word counter increments in the same cycle `o_wren` is high.
    - After the write with word counter = N−1, go to L_DONE.
  - L_DONE: `o_done`=1, `o_hold`=0. All further RX traffic is ignored. Only reset leaves this state.
- Framing error in L_LEN or L_DATA:
  - Set `o_err`, discard the partial word or length, return to L_LEN.
  - The word counter and any words already written are not rolled back.
- Address width: the internal word counter is clog2(DEPTH)+1 bits, zero-extended onto `o_waddr`.

## Timing
- Reset values:
  - `o_waddr`=0, `o_wdata`=0, `o_bmask`=0, `o_wren`=0.
  - `o_hold`=1, `o_done`=0, `o_err`=0.
  - Both FSMs in their idle states (RX_IDLE, L_LEN); byte counter = 0; synchronizer flops = 1.
- Latency:
  - Falling edge at the pin → `byte_vld`: 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles, ±1.
  - `byte_vld` of the 4th byte → `o_wren`: exactly 1 cycle.
- `o_wdata`, `o_waddr` and `o_bmask` are registered and valid in the `o_wren` cycle. `o_waddr` holds its value afterwards.
- Last write:
  - `o_done` rises and `o_hold` falls on the cycle after the last `o_wren`. No cycle exists in which `o_wren`=1 and `o_hold`=0.
  - For N=0, the transition happens the cycle after the 4th length byte.
- Back-to-back bytes with no idle gap are accepted; the stop-bit sample re-arms falling-edge detection immediately.
- `i_reset` low mid-frame or mid-load:
  - All state clears asynchronously, `o_hold` returns to 1 and the load restarts at L_LEN.
  - Memory contents are untouched.

## Test plan
All scenarios run at CLKS_PER_BIT=8.
- Reset check: hold `i_reset`=0 for 5 cycles, release, line idle → `o_hold`=1, `o_done`=0, `o_err`=0, `o_wren` never asserted.
- Basic load: bytes 02 00 00 00, 13 05 10 00, 93 05 20 00 → two `o_wren` pulses:
  - `o_waddr`=0, `o_wdata`=32'h00100513.
  - `o_waddr`=1, `o_wdata`=32'h00200593.
  - `o_bmask`=4'hF both times; `o_done`=1 and `o_hold`=0 one cycle after the second pulse.
- Zero length: bytes 00 00 00 00 → `o_done`=1 with no `o_wren`. A further byte AA produces no write.
- Errors:
  - Length bytes 01 08 00 00 (N=2049 > DEPTH) → `o_err`=1, state L_LEN; following valid length 01 00 00 00 plus one word gives one write at address 0.
  - Stop bit forced 0 on the 2nd data byte → `o_err`=1, no write; resending length and word gives a correct write at address 0.
- Glitch and reset: a 2-cycle low pulse on `i_rx` yields no byte. Asserting `i_reset` after 3 of 4 data bytes, then running a full load, gives writes starting at `o_waddr`=0.
